// File: rtl/ula_multicycle.sv
// rtl/ula_multicycle.sv - pipelined ALU with single-cycle ops and an iterative shift-add multiplier
//
// Purpose:
//   Single-cycle ALU ops (add/sub, shifts, compares, logic) are registered with
//   latency 1. A multiply runs as a shift-add loop, one multiplier bit per cycle,
//   for N cycles (32 in word mode). Optional word mode (W ops) works on the low
//   32 bits and sign-extends the 32-bit result.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   valid_in / ready_out  request handshake (A, B and controls captured on transfer)
//   A, B                  N-bit operands
//   seletor               000 add/sub, 001 sll, 010 slt, 011 sltu,
//                         100 xor, 101 srl/sra, 110 or, 111 and
//   carry_in              1 = subtract (B inverted, +1)
//   arithmetic            1 = arithmetic right shift
//   word                  1 = 32-bit word operation
//   mul                   1 = multiply (overrides seletor)
//   valid_out / ready_in  result handshake
//   Y                     N-bit result
//   zero, negative,
//   carry_out, overflow   adder flags for ALU ops, result-based flags for multiply
//   busy                  multiply in progress

module ula_multicycle #(
  parameter int N       = 64,
  parameter int WORD_EN = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   seletor,
  input  logic         carry_in,
  input  logic         arithmetic,
  input  logic         word,
  input  logic         mul,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [N-1:0] Y,
  output logic         zero,
  output logic         negative,
  output logic         carry_out,
  output logic         overflow,
  output logic         busy
);

  localparam int SW = $clog2(N);
  // Word mode only means something when the datapath is wider than 32 bits.
  localparam bit WORD_OK = (WORD_EN != 0) && (N > 32);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [N-1:0]   acc;
  logic [SW-1:0]  count;
  logic           mul_word;

  logic           word_mode;
  logic           accept;

  logic [N-1:0]   b_eff;
  logic [N-1:0]   sum;
  logic           sum_c;
  logic [31:0]    sum32;
  logic           sum32_c;
  logic           f_zero, f_neg, f_c, f_v;
  logic           lt;
  logic [SW-1:0]  sh_full;
  logic [4:0]     sh_w;
  logic [N-1:0]   r_full;
  logic [31:0]    r_w;
  logic [N-1:0]   alu_y;

  logic [N-1:0]   mul_add;
  logic [N-1:0]   mul_y;

  assign word_mode = WORD_OK && word;
  assign ready_out = !busy && (!valid_out || ready_in);
  assign accept    = valid_in && ready_out;

  // ALU: evaluated straight from the inputs so the result can be registered
  // on the very edge that accepts the request.
  always_comb begin
    b_eff              = B ^ {N{carry_in}};
    {sum_c, sum}       = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, carry_in};
    {sum32_c, sum32}   = {1'b0, A[31:0]} + {1'b0, b_eff[31:0]} + {32'd0, carry_in};

    // Flags always follow the adder so branch compares can use any seletor.
    if (word_mode) begin
      f_zero = (sum32 == 32'd0);
      f_neg  = sum32[31];
      f_c    = sum32_c;
      f_v    = ~(A[31] ^ b_eff[31]) & (A[31] ^ sum32[31]);
    end else begin
      f_zero = (sum == '0);
      f_neg  = sum[N-1];
      f_c    = sum_c;
      f_v    = ~(A[N-1] ^ b_eff[N-1]) & (A[N-1] ^ sum[N-1]);
    end

    sh_full = B[SW-1:0];
    sh_w    = B[4:0];
    lt      = (seletor == 3'b010) ? (f_neg ^ f_v) : !f_c;
    r_full  = '0;
    r_w     = '0;

    case (seletor)
      3'b000: begin
        r_full = sum;
        r_w    = sum32;
      end
      3'b001: begin
        r_full = A << sh_full;
        r_w    = A[31:0] << sh_w;
      end
      3'b010, 3'b011: begin
        r_full = {{(N-1){1'b0}}, lt};
        r_w    = {31'd0, lt};
      end
      3'b100: begin
        r_full = A ^ B;
        r_w    = A[31:0] ^ B[31:0];
      end
      3'b101: begin
        if (arithmetic) begin
          r_full = $signed(A) >>> sh_full;
          r_w    = $signed(A[31:0]) >>> sh_w;
        end else begin
          r_full = A >> sh_full;
          r_w    = A[31:0] >> sh_w;
        end
      end
      3'b110: begin
        r_full = A | B;
        r_w    = A[31:0] | B[31:0];
      end
      default: begin
        r_full = A & B;
        r_w    = A[31:0] & B[31:0];
      end
    endcase

    alu_y = r_full;
    if (word_mode) begin
      alu_y       = {N{r_w[31]}};
      alu_y[31:0] = r_w;
    end
  end

  // Multiply step: the low bits of the running sum depend only on the low
  // bits of the operands, so word mode just stops after 32 iterations.
  always_comb begin
    mul_add = acc + (mplier[0] ? mcand : '0);
    mul_y   = mul_add;
    if (mul_word) begin
      mul_y       = {N{mul_add[31]}};
      mul_y[31:0] = mul_add[31:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      Y         <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      mul_word  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (mul) begin
              // Any previous result was consumed on this same edge.
              state     <= MUL;
              busy      <= 1'b1;
              valid_out <= 1'b0;
              mcand     <= A;
              mplier    <= B;
              acc       <= '0;
              mul_word  <= word_mode;
              count     <= word_mode ? SW'(31) : SW'(N - 1);
            end else begin
              valid_out <= 1'b1;
              Y         <= alu_y;
              zero      <= f_zero;
              negative  <= f_neg;
              carry_out <= f_c;
              overflow  <= f_v;
            end
          end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
          end
        end
        MUL: begin
          acc    <= mul_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid_out <= 1'b1;
            Y         <= mul_y;
            zero      <= (mul_y == '0);
            negative  <= mul_y[N-1];
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
